plb_update_stage: RTL and testbench
===================================

PLB_UPDATE_STAGE -- requirements
Module: plb_update_stage

Interface
REQ-001 Parameter PIPELINE_SLAVE_DATA_WIDTH, default 32, SHALL be the width of the incoming mptw_transaction_t data.
REQ-002 Parameter PIPELINE_MASTER_DATA_WIDTH, default 32, SHALL be the width of the outgoing transaction data.
REQ-003 Localparams PLB_TRANSACTION_DATA_WIDTH = 64 and PLB_TRANSACTION_ADDR_WIDTH = 64 SHALL size the PLB memory port.
REQ-004 clk_i  in  1  single clock; all state SHALL be updated on its rising edge.
REQ-005 rst_ni  in  1  reset, asynchronous and active-low.
REQ-006 stage_slave_valid / stage_slave_ready / stage_slave_data  in / out / in  1 / 1 / PIPELINE_SLAVE_DATA_WIDTH  upstream walker transaction.
REQ-007 stage_master_valid / stage_master_ready / stage_master_data  out / in / out  1 / 1 / PIPELINE_MASTER_DATA_WIDTH  downstream transaction.
REQ-008 plb_master_mem_req / gnt / valid  out / in / in  1 each  PLB write handshake.
REQ-009 plb_master_mem_addr / wdata / rdata  out / out / in  64 each  PLB tag address, write data, read data (rdata unused).
REQ-010 plb_master_mem_we / be / error  out / out / in  1 / 8 / 1  write enable, byte enable, error response.
REQ-011 update_count_o  out  16  number of completed, error-free PLB writes.

Function
REQ-012 Update condition: the captured transaction has valid=1, completed=1, plb_hit=0 and format_error==NO_ERROR.
REQ-013 FSM states: IDLE, REQ, WAIT, OUT.
REQ-014 IDLE: stage_slave_ready=1. On stage_slave_valid, the data SHALL be captured into an internal register; next state is REQ if the update condition holds, else OUT.
REQ-015 In REQ, WAIT and OUT, stage_slave_ready SHALL be 0.
REQ-016 REQ: mem_req=1, we=1, be=8'hFF, addr = captured spa zero-extended to 64 bits, wdata = 64'h1. These values SHALL be held stable until gnt; on gnt the next state is WAIT.
REQ-017 mem_req, we and be SHALL be 0 outside REQ; addr and wdata are don't-care outside REQ.
REQ-018 WAIT: on mem_valid, the next state is OUT. If error=0, update_count_o SHALL increment, saturating at 16'hFFFF. If error=1, the count SHALL NOT change and the transaction SHALL NOT be altered, because PLB write failure is non-fatal.
REQ-019 mem_valid and error SHALL be ignored outside WAIT. A mem_valid in the same cycle as gnt SHALL NOT be honoured; valid is expected at least one cycle after gnt.
REQ-020 OUT: stage_master_valid=1 and stage_master_data = captured transaction, unmodified. Both SHALL hold stable until stage_master_ready; on ready the next state is IDLE.
REQ-021 Latency, accept cycle = 0:
  - bypass: stage_master_valid at cycle 1.
  - update, gnt at cycle 1 and valid at cycle 2: stage_master_valid at cycle 3.
  - each extra gnt or valid wait cycle adds one cycle.
REQ-022 At most one transaction SHALL be in flight; the stage is not pipelined.
REQ-023 Transactions with valid=0 or a format_error SHALL pass through via the bypass path, with no PLB access.

Reset
REQ-024 While rst_ni=0 the following SHALL hold, independent of clk_i:
  - FSM = IDLE
  - captured register = '0
  - update_count_o = 0
  - stage_master_valid = 0
  - plb_master_mem_req = 0, we = 0, be = 0
  - stage_slave_ready = 0
REQ-025 Reset asserted in REQ or WAIT SHALL drop mem_req immediately and abandon the transaction. A mem_valid arriving after reset release SHALL be ignored.
REQ-026 stage_slave_ready SHALL become 1 on the first clock edge after rst_ni deasserts.

Verification
REQ-027 Bypass: accept {valid=1, completed=1, plb_hit=1} -> no mem_req; stage_master_valid at cycle 1 with identical data; update_count_o=0.
REQ-028 Update: accept {valid=1, completed=1, plb_hit=0, spa=32'h8000_1000}, gnt at cycle 1, mem_valid at cycle 2 ->
  - cycle 1: mem_req=1, we=1, addr=64'h0000_0000_8000_1000, wdata=64'h1, be=8'hFF
  - cycle 3: stage_master_valid=1
  - update_count_o=1
REQ-029 Backpressure: gnt delayed 3 cycles and stage_master_ready low 4 cycles -> mem_req, addr and output data stable throughout; stage_slave_ready=0 until the output handshake completes.
REQ-030 Error: mem_valid with error=1 -> transaction forwarded unchanged; update_count_o unchanged; next transaction accepted normally.
REQ-031 Reset in WAIT: assert rst_ni=0 after gnt, then pulse mem_valid after release -> mem_req drops immediately; no output valid; count stays 0; FSM in IDLE.
REQ-032 Saturation: preload 16'hFFFF via 65535 updates, or a forced count -> one more successful update leaves update_count_o=16'hFFFF.

Source files
------------

// File: rtl/plb_update_stage_if.sv
// Valid/ready stream carrying one walker transaction per handshake.
// The producer drives master; the consumer drives slave.
// A handshake completes on any rising edge where both valid and ready are high.
interface plb_update_stage_if #(
    parameter int DATA_WIDTH = 32
) ();
    logic                  valid;
    logic                  ready;
    logic [DATA_WIDTH-1:0] data;

    modport master (
        output valid,
        output data,
        input  ready
    );

    modport slave (
        input  valid,
        input  data,
        output ready
    );
endinterface

// File: rtl/plb_update_stage.sv
// Marks a PLB tag as touched: a completed, missed, error-free walk writes 1 to its tag address.
// Latency: 1 cycle on bypass; 3 cycles on update with 1-cycle gnt and valid, plus wait cycles.
// Backpressure: holds one transaction; slave ready is low until the downstream handshake completes.
module plb_update_stage #(
    parameter int   PIPELINE_SLAVE_DATA_WIDTH  = 32,
    parameter int   PIPELINE_MASTER_DATA_WIDTH = 32,
    localparam int  PLB_TRANSACTION_DATA_WIDTH = 64,
    localparam int  PLB_TRANSACTION_ADDR_WIDTH = 64
) (
    input  logic                                  clk_i,
    input  logic                                  rst_ni,

    plb_update_stage_if.slave                     stage_slave,
    plb_update_stage_if.master                    stage_master,

    output logic                                  plb_master_mem_req,
    input  logic                                  plb_master_mem_gnt,
    input  logic                                  plb_master_mem_valid,
    output logic [PLB_TRANSACTION_ADDR_WIDTH-1:0] plb_master_mem_addr,
    output logic [PLB_TRANSACTION_DATA_WIDTH-1:0] plb_master_mem_wdata,
    input  logic [PLB_TRANSACTION_DATA_WIDTH-1:0] plb_master_mem_rdata,
    output logic                                  plb_master_mem_we,
    output logic [7:0]                            plb_master_mem_be,
    input  logic                                  plb_master_mem_error,

    output logic [15:0]                           update_count_o
);

    // Transaction layout: flags in the low byte, system physical address above them.
    localparam int SPA_WIDTH = PIPELINE_SLAVE_DATA_WIDTH - 8;

    localparam logic [1:0] NO_ERROR = 2'b00;

    typedef struct packed {
        logic [SPA_WIDTH-1:0] spa;
        logic [2:0]           rsvd;
        logic [1:0]           format_error;
        logic                 plb_hit;
        logic                 completed;
        logic                 valid;
    } mptw_transaction_t;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_REQ  = 2'd1;
    localparam logic [1:0] ST_WAIT = 2'd2;
    localparam logic [1:0] ST_OUT  = 2'd3;

    logic [1:0]        state_q;
    logic [1:0]        state_d;
    mptw_transaction_t cap_q;
    mptw_transaction_t in_txn;
    logic              accept_en_q;
    logic              capture;
    logic              update_needed;
    logic              write_ok;
    logic [15:0]       update_count_q;

    assign in_txn = mptw_transaction_t'(stage_slave.data);

    assign update_needed = in_txn.valid
                        && in_txn.completed
                        && !in_txn.plb_hit
                        && (in_txn.format_error == NO_ERROR);

    // Ready is held low through reset and only rises on the first edge after release.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            accept_en_q <= 1'b0;
        end else begin
            accept_en_q <= 1'b1;
        end
    end

    assign stage_slave.ready = accept_en_q && (state_q == ST_IDLE);
    assign capture           = stage_slave.ready && stage_slave.valid;

    // A response counts only in WAIT, so a valid coincident with gnt is dropped.
    assign write_ok = (state_q == ST_WAIT) && plb_master_mem_valid && !plb_master_mem_error;

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (capture) begin
                    state_d = update_needed ? ST_REQ : ST_OUT;
                end
            end
            ST_REQ: begin
                if (plb_master_mem_gnt) begin
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (plb_master_mem_valid) begin
                    state_d = ST_OUT;
                end
            end
            ST_OUT: begin
                if (stage_master.ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cap_q <= '0;
        end else if (capture) begin
            cap_q <= in_txn;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            update_count_q <= 16'h0000;
        end else if (write_ok && (update_count_q != 16'hFFFF)) begin
            update_count_q <= update_count_q + 16'd1;
        end
    end

    assign update_count_o = update_count_q;

    // Request qualifiers decode straight from state so reset drops them without a clock.
    assign plb_master_mem_req   = (state_q == ST_REQ);
    assign plb_master_mem_we    = (state_q == ST_REQ);
    assign plb_master_mem_be    = (state_q == ST_REQ) ? 8'hFF : 8'h00;
    assign plb_master_mem_addr  = PLB_TRANSACTION_ADDR_WIDTH'(cap_q.spa);
    assign plb_master_mem_wdata = PLB_TRANSACTION_DATA_WIDTH'(1);

    // A failed write is non-fatal: the transaction leaves exactly as it arrived.
    assign stage_master.valid = (state_q == ST_OUT);
    assign stage_master.data  = PIPELINE_MASTER_DATA_WIDTH'(cap_q);

    logic unused_rdata;
    assign unused_rdata = ^plb_master_mem_rdata;

endmodule

// File: tb/tb_plb_update_stage.sv
// Directed bench for plb_update_stage: bypass, update, backpressure, error, reset and saturation.
// Inputs change and outputs are sampled on the falling edge.
module tb_plb_update_stage;

    localparam int W = 40;

    // {spa[31:0], rsvd/format_error/plb_hit/completed/valid}
    localparam logic [W-1:0] T_BYP = 40'h12345678_07;
    localparam logic [W-1:0] T_UPD = 40'h80001000_03;
    localparam logic [W-1:0] T_BP  = 40'hCAFE0000_03;
    localparam logic [W-1:0] T_ERR = 40'h00002000_03;
    localparam logic [W-1:0] T_INV = 40'hABCDEF01_00;
    localparam logic [W-1:0] T_FMT = 40'h00004000_0B;
    localparam logic [W-1:0] T_RQR = 40'h00005000_03;
    localparam logic [W-1:0] T_WTR = 40'h00006000_03;
    localparam logic [W-1:0] T_SAT = 40'h00007000_03;

    logic        clk = 1'b0;
    logic        rst_ni;
    logic        mem_req;
    logic        mem_gnt;
    logic        mem_valid;
    logic [63:0] mem_addr;
    logic [63:0] mem_wdata;
    logic [63:0] mem_rdata;
    logic        mem_we;
    logic [7:0]  mem_be;
    logic        mem_error;
    logic [15:0] count;

    int checks = 0;
    int errors = 0;

    plb_update_stage_if #(.DATA_WIDTH(W)) s_if ();
    plb_update_stage_if #(.DATA_WIDTH(W)) m_if ();

    plb_update_stage #(
        .PIPELINE_SLAVE_DATA_WIDTH (W),
        .PIPELINE_MASTER_DATA_WIDTH(W)
    ) dut (
        .clk_i               (clk),
        .rst_ni              (rst_ni),
        .stage_slave         (s_if),
        .stage_master        (m_if),
        .plb_master_mem_req  (mem_req),
        .plb_master_mem_gnt  (mem_gnt),
        .plb_master_mem_valid(mem_valid),
        .plb_master_mem_addr (mem_addr),
        .plb_master_mem_wdata(mem_wdata),
        .plb_master_mem_rdata(mem_rdata),
        .plb_master_mem_we   (mem_we),
        .plb_master_mem_be   (mem_be),
        .plb_master_mem_error(mem_error),
        .update_count_o      (count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    // Presents one transaction for a single cycle; returns at cycle 1.
    task automatic accept(input string tag, input logic [W-1:0] d);
        s_if.valid = 1'b1;
        s_if.data  = d;
        check({tag, "_acc_rdy"}, 64'(s_if.ready), 64'd1);
        step();
        s_if.valid = 1'b0;
    endtask

    // Update with gnt at cycle 1 and response at cycle 2; returns at cycle 4.
    task automatic do_update(input string tag, input logic [W-1:0] d, input logic err);
        accept(tag, d);
        mem_gnt = 1'b1;
        step();
        mem_gnt   = 1'b0;
        mem_valid = 1'b1;
        mem_error = err;
        step();
        mem_valid = 1'b0;
        mem_error = 1'b0;
        check({tag, "_out_vld"}, 64'(m_if.valid), 64'd1);
        check({tag, "_out_dat"}, 64'(m_if.data), 64'(d));
        step();
    endtask

    initial begin
        rst_ni     = 1'b0;
        s_if.valid = 1'b0;
        s_if.data  = '0;
        m_if.ready = 1'b1;
        mem_gnt    = 1'b0;
        mem_valid  = 1'b0;
        mem_error  = 1'b0;
        mem_rdata  = 64'hDEAD_BEEF_0BAD_F00D;

        repeat (3) step();
        check("rst_srdy", 64'(s_if.ready), 64'd0);
        check("rst_mvld", 64'(m_if.valid), 64'd0);
        check("rst_req",  64'(mem_req),    64'd0);
        check("rst_we",   64'(mem_we),     64'd0);
        check("rst_be",   64'(mem_be),     64'd0);
        check("rst_cnt",  64'(count),      64'd0);
        check("rst_mdat", 64'(m_if.data),  64'd0);

        rst_ni = 1'b1;
        #1;
        check("rel_srdy0", 64'(s_if.ready), 64'd0);
        step();
        check("rel_srdy1", 64'(s_if.ready), 64'd1);

        // Bypass: plb_hit set
        accept("byp", T_BYP);
        check("byp_req",  64'(mem_req),    64'd0);
        check("byp_mvld", 64'(m_if.valid), 64'd1);
        check("byp_mdat", 64'(m_if.data),  64'(T_BYP));
        check("byp_srdy", 64'(s_if.ready), 64'd0);
        step();
        check("byp_mvld_done", 64'(m_if.valid), 64'd0);
        check("byp_cnt",       64'(count),      64'd0);

        // Update with minimum latency
        accept("upd", T_UPD);
        check("upd_req",   64'(mem_req),    64'd1);
        check("upd_we",    64'(mem_we),     64'd1);
        check("upd_be",    64'(mem_be),     64'hFF);
        check("upd_addr",  mem_addr,        64'h0000_0000_8000_1000);
        check("upd_wdata", mem_wdata,       64'h1);
        check("upd_mvld1", 64'(m_if.valid), 64'd0);
        mem_gnt = 1'b1;
        step();
        mem_gnt   = 1'b0;
        mem_valid = 1'b1;
        check("upd_req_wait", 64'(mem_req),    64'd0);
        check("upd_be_wait",  64'(mem_be),     64'd0);
        check("upd_mvld2",    64'(m_if.valid), 64'd0);
        step();
        mem_valid = 1'b0;
        check("upd_mvld3", 64'(m_if.valid), 64'd1);
        check("upd_mdat",  64'(m_if.data),  64'(T_UPD));
        check("upd_cnt",   64'(count),      64'd1);
        step();
        check("upd_mvld4", 64'(m_if.valid), 64'd0);

        // Backpressure: gnt late, valid coincident with gnt ignored, output stalled
        m_if.ready = 1'b0;
        accept("bp", T_BP);
        for (int i = 0; i < 3; i++) begin
            check("bp_req_hold",  64'(mem_req),    64'd1);
            check("bp_addr_hold", mem_addr,        64'h0000_0000_CAFE_0000);
            check("bp_srdy_req",  64'(s_if.ready), 64'd0);
            step();
        end
        mem_gnt   = 1'b1;
        mem_valid = 1'b1;
        check("bp_req_gnt", 64'(mem_req), 64'd1);
        step();
        mem_gnt   = 1'b0;
        mem_valid = 1'b0;
        check("bp_req_after_gnt", 64'(mem_req),    64'd0);
        check("bp_no_early_out",  64'(m_if.valid), 64'd0);
        step();
        check("bp_still_wait", 64'(m_if.valid), 64'd0);
        mem_valid = 1'b1;
        step();
        mem_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            check("bp_mvld_hold", 64'(m_if.valid), 64'd1);
            check("bp_mdat_hold", 64'(m_if.data),  64'(T_BP));
            check("bp_srdy_out",  64'(s_if.ready), 64'd0);
            step();
        end
        check("bp_cnt", 64'(count), 64'd2);
        m_if.ready = 1'b1;
        step();
        check("bp_mvld_done", 64'(m_if.valid), 64'd0);
        check("bp_srdy_done", 64'(s_if.ready), 64'd1);

        // Error response: forwarded unchanged, count held
        do_update("err", T_ERR, 1'b1);
        check("err_cnt", 64'(count), 64'd2);

        // Invalid and format-error transactions bypass
        accept("inv", T_INV);
        check("inv_req",  64'(mem_req),    64'd0);
        check("inv_mvld", 64'(m_if.valid), 64'd1);
        check("inv_mdat", 64'(m_if.data),  64'(T_INV));
        step();
        accept("fmt", T_FMT);
        check("fmt_req",  64'(mem_req),    64'd0);
        check("fmt_mdat", 64'(m_if.data),  64'(T_FMT));
        check("fmt_cnt",  64'(count),      64'd2);
        step();

        // Reset during REQ drops the request without a clock edge
        accept("rq_rst", T_RQR);
        check("rq_rst_req_pre", 64'(mem_req), 64'd1);
        rst_ni = 1'b0;
        #1;
        check("rq_rst_req",  64'(mem_req),    64'd0);
        check("rq_rst_we",   64'(mem_we),     64'd0);
        check("rq_rst_be",   64'(mem_be),     64'd0);
        check("rq_rst_srdy", 64'(s_if.ready), 64'd0);
        check("rq_rst_cnt",  64'(count),      64'd0);
        step();
        rst_ni = 1'b1;
        step();

        // Reset during WAIT, then a stale response after release
        accept("wt_rst", T_WTR);
        mem_gnt = 1'b1;
        step();
        mem_gnt = 1'b0;
        #1;
        rst_ni = 1'b0;
        #1;
        check("wt_rst_req",  64'(mem_req),    64'd0);
        check("wt_rst_mvld", 64'(m_if.valid), 64'd0);
        step();
        rst_ni    = 1'b1;
        mem_valid = 1'b1;
        step();
        mem_valid = 1'b0;
        check("wt_rst_mvld2", 64'(m_if.valid), 64'd0);
        check("wt_rst_srdy",  64'(s_if.ready), 64'd1);
        check("wt_rst_cnt",   64'(count),      64'd0);
        step();
        check("wt_rst_mvld3", 64'(m_if.valid), 64'd0);
        check("wt_rst_cnt2",  64'(count),      64'd0);

        // Saturation from a preloaded count
        force dut.update_count_q = 16'hFFFE;
        step();
        release dut.update_count_q;
        step();
        check("sat_preload", 64'(count), 64'hFFFE);
        do_update("sat1", T_SAT, 1'b0);
        check("sat_cnt1", 64'(count), 64'hFFFF);
        do_update("sat2", T_SAT, 1'b0);
        check("sat_cnt2", 64'(count), 64'hFFFF);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
